// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the EX-stage iterative divider: request/ready/signedness
// levels, the 2-bit sequencer state codes and the latched sign flags.
package div_ctrl_pkg;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_NOT_START        = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_SIGNED           = 1'b1;
    localparam logic DIV_NOT_SIGNED       = 1'b0;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    typedef struct packed {
        logic is_signed;
        logic neg_dividend;
        logic neg_divisor;
    } div_sign_t;

    localparam div_sign_t DIV_SIGN_RESET = '{
        is_signed:    DIV_NOT_SIGNED,
        neg_dividend: 1'b0,
        neg_divisor:  1'b0
    };

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring shift-subtract step: shift the partial remainder left, bring in
// the next dividend bit and keep the trial difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_i < divisor_i always holds, so the difference fits in WIDTH bits
    // whenever it is non-negative and the top bit is a clean sign.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = ~diff[WIDTH];
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the shared iterative divider: accepts DIV/DIVU, runs WIDTH
// restoring steps, fixes signs and presents {remainder, quotient} for one cycle.
//
//   state       | meaning
//   DIV_FREE    | idle, sampling start_i
//   DIV_BY_ZERO | divisor was zero, result forced to 0
//   DIV_ON      | one restoring step per cycle, then sign fix-up
//   DIV_END     | result valid, ready_o high for this cycle only
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH);

    logic [1:0]         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   dq_q,      dq_d;
    logic [WIDTH-1:0]   rem_q,     rem_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    div_sign_t          sign_q,    sign_d;
    logic [2*WIDTH-1:0] result_q,  result_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic               neg_op1;
    logic               neg_op2;
    logic               neg_quot;
    logic               neg_rem;

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? ((~v) + WIDTH'(1)) : v;
    endfunction

    // dq_q starts as the dividend magnitude; quotient bits shift in behind
    // the dividend bits being consumed, so it ends up holding the quotient.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (dq_q[WIDTH-1]),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        sign_d    = sign_q;
        result_d  = result_q;

        neg_op1  = (signed_div_i == DIV_SIGNED) & opdata1_i[WIDTH-1];
        neg_op2  = (signed_div_i == DIV_SIGNED) & opdata2_i[WIDTH-1];
        neg_quot = sign_q.is_signed & (sign_q.neg_dividend ^ sign_q.neg_divisor);
        neg_rem  = sign_q.is_signed & sign_q.neg_dividend;

        case (state_q)
            DIV_FREE: begin
                if (start_i != DIV_NOT_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        dq_d      = neg_if(neg_op1, opdata1_i);
                        divisor_d = neg_if(neg_op2, opdata2_i);
                        rem_d     = '0;
                        cnt_d     = '0;
                        sign_d    = '{is_signed:    signed_div_i,
                                      neg_dividend: neg_op1,
                                      neg_divisor:  neg_op2};
                        state_d   = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                result_d = '0;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                if (cnt_q < STEPS) begin
                    rem_d = step_rem;
                    dq_d  = {dq_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {neg_if(neg_rem, rem_q), neg_if(neg_quot, dq_q)};
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                state_d = DIV_FREE;
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase

        // A flush abandons whatever is in flight; ready_o for a DIV_END
        // cycle still shows because it is decoded from the current state.
        if (annul_i && state_q != DIV_FREE) begin
            state_d  = DIV_FREE;
            cnt_d    = '0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            sign_q    <= DIV_SIGN_RESET;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            sign_q    <= sign_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign busy_o   = (state_q != DIV_FREE);

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the iterative divider shared by the EX stage. It accepts a DIV/DIVU request from ex (`div_start_o`, `signed_div_o`, `div_opdata1_o`, `div_opdata2_o`) and converts signed operands to magnitudes. It runs 32 restoring shift-subtract steps, applies sign fix-up, and returns `{remainder, quotient}` for HI/LO with a one-cycle ready pulse. ex holds its stall request until that pulse arrives.

## Interface
- `WIDTH`, 32: operand width; the result is `2*WIDTH`.
- `CNT_W`, 6: step counter width; must hold the value `WIDTH`.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `start_i`, input, 1: division request (`DivStart`); operands are stable while it is high.
- `signed_div_i`, input, 1: 1 selects signed (DIV), 0 selects unsigned (DIVU).
- `opdata1_i`, input, `WIDTH`: dividend.
- `opdata2_i`, input, `WIDTH`: divisor.
- `annul_i`, input, 1: cancel the in-flight operation (pipeline flush).
- `result_o`, output, `2*WIDTH`: `{remainder[63:32], quotient[31:0]}`; valid only while `ready_o` is high.
- `ready_o`, output, 1: result valid (`DivResultReady`); high for exactly one cycle per completed operation.
- `busy_o`, output, 1: high in every state except IDLE.

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE, `start_i`=1 and `annul_i`=0:
  - Divisor 0: go to BYZERO.
  - Otherwise latch the magnitudes (two's-complement negate of negative operands when `signed_div_i`=1), latch the sign flags and signedness, clear the counter, go to ON.
- IDLE, `start_i`=0 or `annul_i`=1: stay in IDLE; nothing is latched.
- BYZERO: load result 0, go to END.
- ON, counter < 32: one restoring step per cycle, then counter +1.
  - Shift the partial remainder left and bring in the next dividend MSB.
  - Compute a 33-bit trial subtract against the divisor.
  - On a non-negative difference, keep the difference and shift in quotient bit 1; otherwise keep the shifted remainder and shift in 0.
- ON, counter = 32: apply fix-up, register `result_o`, go to END.
  - Quotient is negated iff signed and the operand signs differ.
  - Remainder is negated iff signed and the dividend was negative.
- END: `ready_o`=1 and `result_o` valid; unconditionally go to IDLE. `start_i` is ignored in END because it still belongs to the finished instruction.
- `annul_i`=1 in BYZERO, ON or END: go to IDLE at the next edge, clear `result_o`, and raise no further `ready_o`. `ready_o` is Moore-decoded from state, so an annul arriving during END does not suppress that cycle's pulse.
- Signed -2^31 / -1 yields quotient `0x80000000` and remainder 0, with no trap.
- Operands are sampled only on the accepting edge; changes while ON have no effect.

## Timing
- Reset (`rst`=0, asynchronous):
  - State is IDLE and the counter is 0.
  - `result_o`=0, `ready_o`=0, `busy_o`=0.
  - These hold immediately, including mid-operation.
- Normal operation, request accepted at edge E0:
  - Steps execute on edges E1..E32.
  - Fix-up happens at E33.
  - `ready_o` is high in the cycle after E33, which is 34 cycles after acceptance.
- Divide-by-zero: `ready_o` is high in the cycle after E1.
- `busy_o` rises after E0 and falls after the edge that leaves END.
- Back-to-back divides:
  - A held `start_i` is re-sampled in IDLE, which is the cycle after END.
  - Minimum spacing between `ready_o` pulses is 35 cycles for normal operation, 3 cycles for divide-by-zero.
- All outputs are registered or decoded from state, with no combinational path from inputs to outputs.

## Structure
- Shared `defines.v` gains `DivStart`/`DivNotStart`, `DivResultReady`/`DivResultNotReady`, `DivSigned`/`DivNotSigned`, and the 2-bit state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- One sub-module, `div_step`:
  - Purely combinational restoring step.
  - Inputs: partial remainder `WIDTH`, incoming dividend bit, divisor `WIDTH`.
  - Outputs: new remainder `WIDTH`, quotient bit.
  - Instantiated once; `div_ctrl` owns the FSM, counter, operand and sign registers, and fix-up.

## Test plan
- Unsigned 100 / 7 → `result_o`=`0x00000002_0000000E`; `ready_o` 34 cycles after acceptance for exactly 1 cycle; `busy_o` high throughout.
- Signed -7 / 2 → `0xFFFFFFFF_FFFFFFFD`. Signed `0x80000000` / `0xFFFFFFFF` → `0x00000000_80000000`. Unsigned `0xFFFFFFFF` / 1 → `0x00000000_FFFFFFFF`.
- Divisor 0, signed or unsigned → `result_o`=0 with `ready_o` 2 cycles after acceptance; then IDLE.
- `annul_i` pulsed at step 10 → IDLE next edge, `busy_o`=0, no `ready_o`. A new 9 / 3 request then returns `0x00000000_00000003` on schedule.
- `start_i` held high across END with new operands 20 / 6 → the first result appears, END ignores the request, the request is accepted in the next IDLE cycle, and the second result `0x00000002_00000003` arrives 35 cycles after the first.
- `rst` driven low asynchronously at step 5 → `busy_o`, `ready_o`, `result_o` go to 0 immediately. After release, a fresh request completes correctly.
